// File: rtl/modmul_barrett_pipe_if.sv
// Streaming operand/result channel of the Barrett modular multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface modmul_barrett_pipe_if #(
    parameter int W     = 64,
    parameter int TAG_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/modmul_barrett_pipe.sv
// Six-stage Barrett modular multiplier: out_data = (a*b) mod q, one operation per cycle.
// Modulus and Barrett constant sit in config registers that only reload while the pipe is empty.
module modmul_barrett_pipe #(
    parameter int W     = 64,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [W-1:0]          cfg_q,
    input  logic [W:0]            cfg_mu,
    input  logic [7:0]            cfg_k,
    output logic                  busy,
    modmul_barrett_pipe_if.slave  io
);
    localparam int ZW = 2 * W;
    localparam int QW = 3 * W + 1;
    localparam int RW = W + 2;

    logic [W-1:0]     cfg_q_r;
    logic [W:0]       cfg_mu_r;
    logic [7:0]       cfg_k_r;
    logic             cfg_valid_r;

    logic [5:0]       v_r;
    logic [TAG_W-1:0] tag_r [6];
    logic [ZW-1:0]    z1_r;
    logic [QW-1:0]    q2_r;
    logic [RW-1:0]    z2_r;
    logic [RW-1:0]    z3_r;
    logic [RW-1:0]    p3_r;
    logic [RW-1:0]    r4_r;
    logic [RW-1:0]    r5_r;
    logic [W-1:0]     d6_r;

    logic             en_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [QW-1:0]    q2_s;
    logic [RW-1:0]    p3_s;

    // One conditional subtraction of the modulus; the remainder never needs more than W+2 bits.
    function automatic logic [RW-1:0] csub(input logic [RW-1:0] x, input logic [W-1:0] m);
        logic [RW-1:0] mx;
        mx = {2'b00, m};
        return (x >= mx) ? (x - mx) : x;
    endfunction

    // Handshake decode and the two wide Barrett products.
    always_comb begin
        en_s       = ~v_r[5] | io.out_ready;
        in_ready_s = en_s & cfg_valid_r & ~cfg_we;
        accept_s   = io.in_valid & in_ready_s;
        q2_s       = QW'(z1_r >> (cfg_k_r - 8'd1)) * QW'(cfg_mu_r);
        // Only the low W+2 bits of q3*q matter since the remainder is taken mod 2^(W+2).
        p3_s       = RW'((q2_r >> (cfg_k_r + 8'd1)) * QW'(cfg_q_r));
    end

    assign io.in_ready  = in_ready_s;
    assign io.out_valid = v_r[5];
    assign io.out_data  = d6_r;
    assign io.out_tag   = tag_r[5];
    assign busy         = |v_r;

    // Config registers: a write is dropped while any operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q_r     <= {W{1'b0}};
            cfg_mu_r    <= {(W + 1){1'b0}};
            cfg_k_r     <= 8'd0;
            cfg_valid_r <= 1'b0;
        end else if (cfg_we && !busy) begin
            cfg_q_r     <= cfg_q;
            cfg_mu_r    <= cfg_mu;
            cfg_k_r     <= cfg_k;
            cfg_valid_r <= 1'b1;
        end
    end

    // Pipeline: all stages advance together when the output register can be refilled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r  <= 6'd0;
            z1_r <= {ZW{1'b0}};
            q2_r <= {QW{1'b0}};
            z2_r <= {RW{1'b0}};
            z3_r <= {RW{1'b0}};
            p3_r <= {RW{1'b0}};
            r4_r <= {RW{1'b0}};
            r5_r <= {RW{1'b0}};
            d6_r <= {W{1'b0}};
            for (int i = 0; i < 6; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
        end else if (en_s) begin
            v_r      <= {v_r[4:0], accept_s};
            tag_r[0] <= io.in_tag;
            for (int i = 1; i < 6; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            z1_r <= ZW'(io.in_a) * ZW'(io.in_b);
            q2_r <= q2_s;
            z2_r <= z1_r[RW-1:0];
            p3_r <= p3_s;
            z3_r <= z2_r;
            r4_r <= z3_r - p3_r;
            r5_r <= csub(r4_r, cfg_q_r);
            d6_r <= W'(csub(r5_r, cfg_q_r));
        end
    end
endmodule

// File: tb/tb_modmul_barrett_pipe.sv
// Directed bench for modmul_barrett_pipe: a W=16 instance for streaming/stall/reset behaviour
// and a W=64 instance for the wide-modulus vectors.
module tb_modmul_barrett_pipe;
    localparam int W  = 16;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cfg_we;
    logic [W-1:0]  cfg_q;
    logic [W:0]    cfg_mu;
    logic [7:0]    cfg_k;
    logic          busy;
    modmul_barrett_pipe_if #(.W(W), .TAG_W(TW)) io ();
    modmul_barrett_pipe #(.W(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_mu(cfg_mu),
        .cfg_k(cfg_k), .busy(busy), .io(io)
    );

    logic          cfg64_we;
    logic [63:0]   cfg64_q;
    logic [64:0]   cfg64_mu;
    logic [7:0]    cfg64_k;
    logic          busy64;
    modmul_barrett_pipe_if #(.W(64), .TAG_W(TW)) io64 ();
    modmul_barrett_pipe #(.W(64), .TAG_W(TW)) dut64 (
        .clk(clk), .rst(rst), .cfg_we(cfg64_we), .cfg_q(cfg64_q), .cfg_mu(cfg64_mu),
        .cfg_k(cfg64_k), .busy(busy64), .io(io64)
    );

    int n_checks;
    int n_pass;
    logic [W-1:0] va [32];
    logic [W-1:0] vb [32];
    logic [W-1:0] ve [32];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic cfg16(input logic [W-1:0] q, input logic [W:0] mu, input logic [7:0] k);
        cfg_we = 1'b1; cfg_q = q; cfg_mu = mu; cfg_k = k;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Streams va/vb through the W=16 instance; expected results in ve, tags 1..n.
    task automatic run16(input int nops, input bit rnd_ready, input bit chk_lat);
        int sent, got, cyc;
        int acc [32];
        bit in_fire, stalled;
        logic [W-1:0]  held_d;
        logic [TW-1:0] held_t;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        held_d = '0; held_t = '0;
        io.in_valid  = (nops > 0);
        io.in_a      = va[0];
        io.in_b      = vb[0];
        io.in_tag    = 8'd1;
        io.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (got < nops && cyc < 400) begin
            @(negedge clk);
            in_fire = io.in_valid && io.in_ready;
            if (stalled) begin
                check("stall_valid_held", 64'(io.out_valid), 64'd1);
                check("stall_data_held", 64'(io.out_data), 64'(held_d));
                check("stall_tag_held", 64'(io.out_tag), 64'(held_t));
            end
            if (io.out_valid && !io.out_ready) begin
                check("stall_in_ready", 64'(io.in_ready), 64'd0);
                stalled = 1'b1; held_d = io.out_data; held_t = io.out_tag;
            end else begin
                stalled = 1'b0;
            end
            if (io.out_valid && io.out_ready) begin
                check("result", 64'(io.out_data), 64'(ve[got]));
                check("tag", 64'(io.out_tag), 64'(got + 1));
                if (chk_lat) check("latency", 64'(cyc - acc[got]), 64'd6);
                got++;
            end
            if (in_fire) begin
                acc[sent] = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            io.in_valid = (sent < nops);
            if (sent < nops) begin
                io.in_a = va[sent]; io.in_b = vb[sent]; io.in_tag = 8'(sent + 1);
            end
            io.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("drained", 64'(got), 64'(nops));
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input string nm);
        int n;
        io64.in_valid = 1'b1; io64.in_a = a; io64.in_b = b; io64.in_tag = 8'h5A;
        io64.out_ready = 1'b1;
        @(posedge clk); #1;
        io64.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!io64.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        check({nm, "_valid"}, 64'(io64.out_valid), 64'd1);
        check(nm, io64.out_data, exp);
        check({nm, "_tag"}, 64'(io64.out_tag), 64'h5A);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, seen, bad;
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_q = '0; cfg_mu = '0; cfg_k = '0;
        cfg64_we = 1'b0; cfg64_q = '0; cfg64_mu = '0; cfg64_k = '0;
        io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.in_tag = '0; io.out_ready = 1'b1;
        io64.in_valid = 1'b0; io64.in_a = '0; io64.in_b = '0; io64.in_tag = '0;
        io64.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(io.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(io.in_ready), 64'd0);
        check("rst_out_data", 64'(io.out_data), 64'd0);
        check("rst_out_tag", 64'(io.out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("no_cfg_in_ready", 64'(io.in_ready), 64'd0);
        @(posedge clk); #1;

        cfg64_we = 1'b1; cfg64_q = 64'hFFFF_FFFF_0000_0001;
        cfg64_mu = 65'h1_0000_0000_FFFF_FFFF; cfg64_k = 8'd64;
        cfg16(16'd97, 17'd168, 8'd7);
        cfg64_we = 1'b0;

        // Single op latency: 96*96 mod 97 = 1
        va[0] = 16'd96; vb[0] = 16'd96; ve[0] = 16'd1;
        run16(1, 1'b0, 1'b1);

        // Back-to-back ops with fixed latency, i.e. consecutive outputs
        va[0] = 16'd50; vb[0] = 16'd2;  ve[0] = 16'd3;
        va[1] = 16'd0;  vb[1] = 16'd55; ve[1] = 16'd0;
        va[2] = 16'd96; vb[2] = 16'd1;  ve[2] = 16'd96;
        run16(3, 1'b0, 1'b1);

        // Random operands under a random out_ready pattern
        for (int i = 0; i < 20; i++) begin
            va[i] = 16'($urandom_range(0, 96));
            vb[i] = 16'($urandom_range(0, 96));
            ve[i] = 16'((int'(va[i]) * int'(vb[i])) % 97);
        end
        run16(20, 1'b1, 1'b0);

        op64(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'd1, "w64_qm1_sq");
        op64(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
             "w64_2p32_sq");

        // Config write while busy is ignored: 50*3 mod 97 = 53 (q=101 would give 49)
        io.in_valid = 1'b1; io.in_a = 16'd50; io.in_b = 16'd3; io.in_tag = 8'h21;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        cfg_we = 1'b1; cfg_q = 16'd101; cfg_mu = 17'd162; cfg_k = 8'd7;
        @(negedge clk);
        check("busy_in_flight", 64'(busy), 64'd1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        n = 0;
        @(negedge clk);
        while (!io.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        check("busy_cfg_old_q", 64'(io.out_data), 64'd53);
        check("busy_cfg_tag", 64'(io.out_tag), 64'h21);
        @(posedge clk); #1;
        // 96*96 mod 97 = 1 (mod 101 would be 25)
        va[0] = 16'd96; vb[0] = 16'd96; ve[0] = 16'd1;
        run16(1, 1'b0, 1'b1);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            io.in_valid = 1'b1; io.in_a = 16'(10 + i); io.in_b = 16'd20; io.in_tag = 8'(i);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        io.in_valid = 1'b1;
        seen = 0; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (io.out_valid) seen++;
            if (busy || io.in_ready) bad++;
            @(posedge clk); #1;
        end
        check("rst_flight_no_out", 64'(seen), 64'd0);
        check("rst_flight_idle", 64'(bad), 64'd0);
        io.in_valid = 1'b0;
        cfg16(16'd97, 17'd168, 8'd7);
        @(negedge clk);
        check("in_ready_after_cfg", 64'(io.in_ready), 64'd1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/modmul_barrett_pipe.md
MODMUL_BARRETT_PIPE -- requirements
Module: modmul_barrett_pipe

Interface
REQ-001 Parameter W, default 64: operand/modulus width in bits (legal 8..64).
REQ-002 Parameter TAG_W, default 8: width of the sideband tag carried alongside each operation.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cfg_we  in  1  pulse that loads the cfg_q, cfg_mu and cfg_k inputs.
REQ-006 cfg_q  in  W  modulus q, odd, q >= 3.
REQ-007 cfg_mu  in  W+1  Barrett constant floor(2^(2k)/q).
REQ-008 cfg_k  in  8  bit length of q, 2 <= k <= W.
REQ-009 busy  out  1  high while any pipeline stage holds a valid operation.
REQ-010 in_valid / in_ready  in/out  1/1  input handshake.
REQ-011 in_a, in_b  in  W each  operands; caller guarantees a < q and b < q.
REQ-012 in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
REQ-013 out_valid / out_ready  out/in  1/1  output handshake.
REQ-014 out_data  out  W  result t = (a*b) mod q.
REQ-015 out_tag  out  TAG_W  tag of the result on out_data.

Function
REQ-016 The config registers SHALL load on cfg_we only when busy=0; cfg_we while busy=1 SHALL be ignored, and cfg_valid SHALL set on a successful load.
REQ-017 Global advance: en = !out_valid | out_ready; all six stages SHALL shift only when en=1 and SHALL hold data and valid bits otherwise.
REQ-018 in_ready SHALL equal en & cfg_valid & !cfg_we; a transfer SHALL occur when in_valid & in_ready.
REQ-019 S1 SHALL compute z = a*b, 2W bits.
REQ-020 S2 SHALL compute q2 = (z >> (k-1)) * mu at full width.
REQ-021 S3 SHALL compute q3 = q2 >> (k+1) and p = q3*q.
REQ-022 S4 SHALL compute r = (z - p) mod 2^(W+2); r SHALL be in [0, 3q).
REQ-023 S5 SHALL subtract q if r >= q; S6 SHALL subtract q again if the remainder is still >= q, and S6 SHALL register out_data.
REQ-024 Latency SHALL be exactly 6 cycles from accepted input to out_valid when no stall occurs; throughput SHALL be 1 operation per cycle.
REQ-025 Results SHALL emerge in input order, each with its own tag; no operation SHALL be lost or duplicated under any out_ready pattern.
REQ-026 out_data and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Input and output transfers in the same cycle SHALL both complete, with no bubble inserted.
REQ-028 Operands violating a,b < q SHALL give an unspecified out_data but correct handshake behaviour.

Reset
REQ-029 On rst=1 at a clock edge, all stage valid bits, out_valid, busy, cfg_valid and in_ready SHALL be 0, and out_data and out_tag SHALL be 0.
REQ-030 rst mid-operation SHALL discard all in-flight operations; no result SHALL appear after reset releases.
REQ-031 Config registers SHALL clear on reset, and a new cfg_we SHALL be required before in_ready can assert.

Verification
REQ-032 W=16, cfg q=97, k=7, mu=168; a=96, b=96, out_ready=1 -> out_data=1 exactly 6 cycles after accept.
REQ-033 Same cfg; back-to-back ops (50,2), (0,55), (96,1) tags 1,2,3 -> outputs 3, 0, 96 on consecutive cycles, tags 1,2,3.
REQ-034 W=64, q=0xFFFFFFFF00000001, k=64, mu=0x1_0000_0000_FFFF_FFFF; a=b=q-1 -> out_data=1; a=2^32, b=2^32 -> out_data=0xFFFFFFFF.
REQ-035 Stream 20 random ops with random out_ready (50%) -> results match a golden model in order, out_data stable while stalled, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-036 cfg_we with a new q while busy=1 -> ignored, and in-flight results use the old q; rst asserted with 3 ops in flight -> no out_valid afterwards, busy=0 and in_ready=0 until cfg_we.
